// File: rtl/ysyx_24120013_exu_pipe_pkg.sv
// Shared definitions for the execute unit: op codes, FSM states and op-class helpers.
package ysyx_24120013_exu_pipe_pkg;

    // RV32I ALU operations (single cycle)
    localparam logic [4:0] EXU_OP_ADD    = 5'd0;
    localparam logic [4:0] EXU_OP_SUB    = 5'd1;
    localparam logic [4:0] EXU_OP_AND    = 5'd2;
    localparam logic [4:0] EXU_OP_OR     = 5'd3;
    localparam logic [4:0] EXU_OP_XOR    = 5'd4;
    localparam logic [4:0] EXU_OP_SLT    = 5'd5;
    localparam logic [4:0] EXU_OP_SLTU   = 5'd6;
    localparam logic [4:0] EXU_OP_SLL    = 5'd7;
    localparam logic [4:0] EXU_OP_SRL    = 5'd8;
    localparam logic [4:0] EXU_OP_SRA    = 5'd9;
    localparam logic [4:0] EXU_OP_PASSB  = 5'd10;

    // RV32M operations (iterative); bit 2 distinguishes divide from multiply
    localparam logic [4:0] EXU_OP_MUL    = 5'd16;
    localparam logic [4:0] EXU_OP_MULH   = 5'd17;
    localparam logic [4:0] EXU_OP_MULHSU = 5'd18;
    localparam logic [4:0] EXU_OP_MULHU  = 5'd19;
    localparam logic [4:0] EXU_OP_DIV    = 5'd20;
    localparam logic [4:0] EXU_OP_DIVU   = 5'd21;
    localparam logic [4:0] EXU_OP_REM    = 5'd22;
    localparam logic [4:0] EXU_OP_REMU   = 5'd23;

    // IDLE accepts ops, CALC iterates, FIX registers the signed-corrected result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } exu_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_alu(input logic [4:0] op);
        return op <= EXU_OP_PASSB;
    endfunction

endpackage

// File: rtl/ysyx_24120013_muldiv.sv
// Iterative RV32M engine: radix-2 shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, followed by a sign fix-up on the final value.
module ysyx_24120013_muldiv
    import ysyx_24120013_exu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic                  running;
    logic                  fix;
    logic [CNT_W-1:0]      cnt;

    logic [PW-1:0]         acc_p0;
    logic [DATA_WIDTH-1:0] opnd_p0;
    logic [DATA_WIDTH-1:0] src1_p0;
    logic [4:0]            op_p0;
    logic                  neg_q_p0;
    logic                  neg_r_p0;
    logic                  zero_p0;

    logic                  a_sgn;
    logic                  b_sgn;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;

    // acc = {partial, multiplier}; add multiplicand when the low bit is set, then shift right
    function automatic logic [PW-1:0] mul_step(input logic [PW-1:0] acc, input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, acc[PW-1:DATA_WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        return {sum, acc[DATA_WIDTH-1:1]};
    endfunction

    // acc = {remainder, quotient/dividend}; shift left one bit and trial-subtract the divisor
    function automatic logic [PW-1:0] div_step(input logic [PW-1:0] acc, input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH:0] r_sh;
        logic [DATA_WIDTH:0] diff;
        r_sh = {acc[PW-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        diff = r_sh - {1'b0, d};
        if (!diff[DATA_WIDTH])
            return {diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
        return {r_sh[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // Apply signs and the divide-by-zero rules to the raw magnitude result
    function automatic logic [DATA_WIDTH-1:0] fixup(
        input logic [4:0]            f_op,
        input logic [PW-1:0]         acc,
        input logic                  neg_q,
        input logic                  neg_r,
        input logic                  zero,
        input logic [DATA_WIDTH-1:0] src1
    );
        logic [PW-1:0]         prod;
        logic [DATA_WIDTH-1:0] quo;
        logic [DATA_WIDTH-1:0] rmd;
        prod = neg_q ? -acc : acc;
        quo  = acc[DATA_WIDTH-1:0];
        rmd  = acc[PW-1:DATA_WIDTH];
        case (f_op)
            EXU_OP_MUL:    return prod[DATA_WIDTH-1:0];
            EXU_OP_MULH,
            EXU_OP_MULHSU,
            EXU_OP_MULHU:  return prod[PW-1:DATA_WIDTH];
            EXU_OP_DIV:    return zero ? '1 : (neg_q ? -quo : quo);
            EXU_OP_DIVU:   return zero ? '1 : quo;
            EXU_OP_REM:    return zero ? src1 : (neg_r ? -rmd : rmd);
            EXU_OP_REMU:   return zero ? src1 : rmd;
            default:       return '0;
        endcase
    endfunction

    // Decide operand signedness and take magnitudes at start
    always_comb begin
        a_sgn = a[DATA_WIDTH-1] && (op == EXU_OP_MULH || op == EXU_OP_MULHSU ||
                                    op == EXU_OP_DIV  || op == EXU_OP_REM);
        b_sgn = b[DATA_WIDTH-1] && (op == EXU_OP_MULH || op == EXU_OP_DIV || op == EXU_OP_REM);
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;
    end

    assign last   = running && (cnt == CNT_W'(DATA_WIDTH - 1));
    assign done   = fix;
    assign result = fixup(op_p0, acc_p0, neg_q_p0, neg_r_p0, zero_p0, src1_p0);

    // Iteration control: counter runs DATA_WIDTH steps, then one fix-up cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            fix     <= 1'b0;
            cnt     <= '0;
        end else begin
            fix <= last;
            if (start) begin
                running <= 1'b1;
                cnt     <= '0;
            end else if (running) begin
                cnt <= cnt + 1'b1;
                if (last)
                    running <= 1'b0;
            end
        end
    end

    // ---- stage p0: operand capture and per-cycle datapath step ----
    always_ff @(posedge clk) begin
        if (start) begin
            op_p0    <= op;
            neg_q_p0 <= a_sgn ^ b_sgn;
            neg_r_p0 <= a_sgn;
            zero_p0  <= (b == '0);
            src1_p0  <= a;
            if (op[2]) begin
                opnd_p0 <= b_mag;
                acc_p0  <= {{DATA_WIDTH{1'b0}}, a_mag};
            end else begin
                opnd_p0 <= a_mag;
                acc_p0  <= {{DATA_WIDTH{1'b0}}, b_mag};
            end
        end else if (running) begin
            acc_p0 <= op_p0[2] ? div_step(acc_p0, opnd_p0) : mul_step(acc_p0, opnd_p0);
        end
    end

endmodule

// File: rtl/ysyx_24120013_exu_pipe.sv
// Execute unit: single-cycle ALU plus optional iterative mul/div, with a
// valid/ready handshake on both sides and a held output register toward WBU.
module ysyx_24120013_exu_pipe
    import ysyx_24120013_exu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter bit MULDIV_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_rd_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_AW-1:0]     out_rd,
    output logic                  out_rd_wen,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  busy
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    exu_state_t            state;
    exu_state_t            state_nxt;

    logic                  accept;
    logic                  take_m;
    logic                  take_alu;
    logic                  wen_now;

    logic                  mdu_last;
    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] mdu_result;

    logic [REG_AW-1:0]     m_rd_p0;
    logic                  m_wen_p0;

    // Combinational RV32I ALU; undefined codes produce zero
    function automatic logic [DATA_WIDTH-1:0] alu(
        input logic [4:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [SH_W-1:0]              sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[SH_W-1:0];
        case (op)
            EXU_OP_ADD:   return a + b;
            EXU_OP_SUB:   return a - b;
            EXU_OP_AND:   return a & b;
            EXU_OP_OR:    return a | b;
            EXU_OP_XOR:   return a ^ b;
            EXU_OP_SLT:   return {{(DATA_WIDTH-1){1'b0}}, sa < sb};
            EXU_OP_SLTU:  return {{(DATA_WIDTH-1){1'b0}}, a < b};
            EXU_OP_SLL:   return a << sh;
            EXU_OP_SRL:   return a >> sh;
            EXU_OP_SRA:   return $unsigned(sa >>> sh);
            EXU_OP_PASSB: return b;
            default:      return '0;
        endcase
    endfunction

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign take_m   = accept && MULDIV_EN && is_muldiv(in_op);
    assign take_alu = accept && !take_m;
    assign wen_now  = in_rd_wen && (in_rd != '0);
    assign busy     = (state == ST_CALC);

    generate
        if (MULDIV_EN) begin : g_muldiv
            ysyx_24120013_muldiv #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .start  (take_m),
                .op     (in_op),
                .a      (in_src1),
                .b      (in_src2),
                .last   (mdu_last),
                .done   (mdu_done),
                .result (mdu_result)
            );
        end else begin : g_no_muldiv
            assign mdu_last   = 1'b0;
            assign mdu_done   = 1'b0;
            assign mdu_result = '0;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: an M op holds off new ops until its result is registered
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take_m)   state_nxt = ST_CALC;
            ST_CALC: if (mdu_last) state_nxt = ST_FIX;
            ST_FIX:                state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p0: destination capture for an in-flight M op ----
    always_ff @(posedge clk) begin
        if (take_m) begin
            m_rd_p0  <= in_rd;
            m_wen_p0 <= wen_now;
        end
    end

    // ---- output stage: load ALU or M result, hold until WBU accepts ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
            out_wdata  <= '0;
        end else if (take_alu) begin
            out_valid  <= 1'b1;
            out_rd     <= in_rd;
            out_rd_wen <= wen_now && is_alu(in_op);
            out_wdata  <= alu(in_op, in_src1, in_src2);
        end else if (state == ST_FIX && mdu_done) begin
            out_valid  <= 1'b1;
            out_rd     <= m_rd_p0;
            out_rd_wen <= m_wen_p0;
            out_wdata  <= mdu_result;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_24120013_exu_pipe.sv
// Scoreboard bench for the execute unit: the stimulus process pushes expected
// results from a reference model, the monitor pops them on each WBU handshake.
module tb_ysyx_24120013_exu_pipe;
    import ysyx_24120013_exu_pipe_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [31:0] out_wdata;
    logic        busy;

    logic        man_ready = 1'b1;
    logic        rnd_ready = 1'b1;
    logic        rand_bp = 1'b0;
    assign out_ready = rand_bp ? rnd_ready : man_ready;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          busy_total = 0;
    bit          presented = 1'b0;

    ysyx_24120013_exu_pipe #(
        .DATA_WIDTH (32),
        .REG_AW     (5),
        .MULDIV_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_rd      (in_rd),
        .in_rd_wen  (in_rd_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_rd_wen (out_rd_wen),
        .out_wdata  (out_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (busy) busy_total <= busy_total + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic bit defined_op(input logic [4:0] op);
        return (op <= 5'd10) || (op >= 5'd16 && op <= 5'd23);
    endfunction

    function automatic bit m_op(input logic [4:0] op);
        return op >= 5'd16 && op <= 5'd23;
    endfunction

    // Reference behaviour written with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb2;
        longint unsigned ua;
        longint unsigned ub;
        logic [4:0]      sh;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sh  = b[4:0];
        case (op)
            EXU_OP_ADD:    return a + b;
            EXU_OP_SUB:    return a - b;
            EXU_OP_AND:    return a & b;
            EXU_OP_OR:     return a | b;
            EXU_OP_XOR:    return a ^ b;
            EXU_OP_SLT:    return (sa < sb2) ? 32'd1 : 32'd0;
            EXU_OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            EXU_OP_SLL:    return a << sh;
            EXU_OP_SRL:    return a >> sh;
            EXU_OP_SRA:    return 32'(sa >>> sh);
            EXU_OP_PASSB:  return b;
            EXU_OP_MUL:    return 32'(ua * ub);
            EXU_OP_MULH:   return 32'((sa * sb2) >>> 32);
            EXU_OP_MULHSU: return 32'((sa * longint'(ub)) >>> 32);
            EXU_OP_MULHU:  return 32'((ua * ub) >> 32);
            EXU_OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb2);
            EXU_OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            EXU_OP_REM:    return (b == 0) ? a : 32'(sa % sb2);
            EXU_OP_REMU:   return (b == 0) ? a : 32'(ua % ub);
            default:       return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: latency on first presentation, contents on handshake
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            presented = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got out_valid=1 wdata=0x%08h, required no result", out_wdata);
            end else begin
                if (!presented) begin
                    check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    presented = 1'b1;
                end
                if (out_ready) begin
                    mon_e = sb.pop_front();
                    check("wdata", out_wdata, mon_e.wdata);
                    check("rd", 32'(out_rd), 32'(mon_e.rd));
                    check("rd_wen", 32'(out_rd_wen), 32'(mon_e.wen));
                    presented = 1'b0;
                end
            end
        end
    end

    // Present one op and hold it until accepted; called and returns at a negedge
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic wen, input bit push);
        int   n;
        exp_t e;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        in_rd     = rd;
        in_rd_wen = wen;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.rd    = rd;
            e.wen   = wen && (rd != 0) && defined_op(op);
            e.wdata = model(op, a, b);
            e.acc   = cyc + 1;
            e.lat   = m_op(op) ? 33 : 0;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b0;
        int          vcount;
        logic [4:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_wdata", out_wdata, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // First ALU op and signed/unsigned compare
        send(EXU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b1);
        check("add_valid_next_cycle", 32'(out_valid), 32'd1);
        send(EXU_OP_SLT, 32'h8000_0000, 32'h1, 5'd4, 1'b1, 1'b1);
        send(EXU_OP_SLTU, 32'h8000_0000, 32'h1, 5'd5, 1'b1, 1'b1);
        wait_drain();

        // Back-to-back ADDs with rd=0 on the second
        send(EXU_OP_ADD, 32'd10, 32'd1, 5'd1, 1'b1, 1'b1);
        send(EXU_OP_ADD, 32'd20, 32'd2, 5'd0, 1'b1, 1'b1);
        send(EXU_OP_ADD, 32'd30, 32'd3, 5'd2, 1'b1, 1'b1);
        send(EXU_OP_ADD, 32'd40, 32'd4, 5'd7, 1'b1, 1'b1);
        wait_drain();

        // Backpressure on an XOR result
        man_ready = 1'b0;
        send(EXU_OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5'd9, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #2;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_wdata_stable", out_wdata, 32'hAA55_F0F0);
            check("bp_rd_stable", 32'(out_rd), 32'd9);
            @(negedge clk);
        end
        man_ready = 1'b1;
        @(negedge clk);
        #2;
        check("bp_drained", 32'(out_valid), 32'd0);
        wait_drain();

        // Multiply: latency via scoreboard, busy duration here
        b0 = busy_total;
        send(EXU_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b1);
        wait_drain();
        check("mulh_busy_cycles", 32'(busy_total - b0), 32'd32);
        b0 = busy_total;
        send(EXU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1);
        wait_drain();
        check("mulhu_busy_cycles", 32'(busy_total - b0), 32'd32);
        b0 = busy_total;
        send(EXU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1);
        wait_drain();
        check("mul_busy_cycles", 32'(busy_total - b0), 32'd32);

        // Divide corner cases
        send(EXU_OP_DIV, 32'd7, 32'd0, 5'd13, 1'b1, 1'b1);
        send(EXU_OP_REMU, 32'd7, 32'd0, 5'd14, 1'b1, 1'b1);
        send(EXU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 1'b1);
        send(EXU_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 1'b1);
        send(EXU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd17, 1'b1, 1'b1);
        send(EXU_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd18, 1'b1, 1'b1);
        wait_drain();

        // Asynchronous reset in the middle of a DIVU
        send(EXU_OP_DIVU, 32'h1234_5678, 32'd3, 5'd19, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_wdata", out_wdata, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("no_result_after_reset", 32'(vcount), 32'd0);
        send(EXU_OP_ADD, 32'd100, 32'd23, 5'd20, 1'b1, 1'b1);
        wait_drain();

        // Randomized mix with random WBU backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op = 5'($urandom_range(0, 10));
                5, 6, 7:       op = 5'(16 + $urandom_range(0, 7));
                default:       op = 5'($urandom_range(0, 31));
            endcase
            ra = pick_operand();
            rb = pick_operand();
            send(op, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();
        rand_bp = 1'b0;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
